// File: rtl/seg_seq_pkg.sv
// Shared types and constants for the seven-segment digit sequencer.
// Holds the FSM state encoding, the BCD limit, the segment table and the step helper.
package seg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-high segments, bit0 = a .. bit6 = g; entry n is the pattern for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic down);
    if (down) begin
      return (d == 4'd0) ? BCD_MAX : d - 4'd1;
    end
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to seven-segment decoder; codes 10..15 blank the display.
module seg7_bcd_decode
  import seg_seq_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    if (bcd_i <= BCD_MAX) begin
      seg_o = SEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/seg_display_sequencer.sv
// Run-control sequencer stepping a BCD digit at a programmable rate with registered segments.
// Optional decimal-point blink at the step rate is built when SEG_DP_BLINK_EN is defined.
//
// state | meaning
// IDLE  | after reset; prescaler and digit hold until start
// RUN   | prescaler counts; digit steps every TICK_DIV cycles
// PAUSE | prescaler and digit hold mid-period; start resumes
module seg_display_sequencer
  import seg_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic [6:0] segments,
  output logic       tick,
  output logic       running,
  output logic       dp
);

  localparam logic [PRESCALE_W-1:0] PRESC_TC = PRESCALE_W'(TICK_DIV - 1);

  seq_state_e            state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [3:0]            digit_q, digit_d;
  logic [6:0]            seg_q, seg_d;
  logic                  tick_q, tick_d;
  logic                  running_q, running_d;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    digit_d = digit_q;
    tick_d  = 1'b0;
    if (load) begin
      // A load restarts the period and suppresses any step due on this edge.
      digit_d = (load_val > BCD_MAX) ? BCD_MAX : load_val;
      presc_d = '0;
    end else begin
      if (state_q == RUN) begin
        if (presc_q == PRESC_TC) begin
          presc_d = '0;
          tick_d  = 1'b1;
          digit_d = bcd_step(digit_q, dir);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      unique case (state_q)
        IDLE:    if (!stop && start) state_d = RUN;
        RUN:     if (stop)           state_d = PAUSE;
        PAUSE:   if (!stop && start) state_d = RUN;
        default:                     state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  seg7_bcd_decode u_decode (
    .bcd_i (digit_d),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      digit_q   <= 4'd0;
      seg_q     <= 7'h3F;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

`ifdef SEG_DP_BLINK_EN
  localparam logic [PRESCALE_W-1:0] DP_HALF = PRESCALE_W'(TICK_DIV / 2);

  logic dp_q, dp_d;

  assign dp_d = (state_d == RUN) && (presc_d < DP_HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= 1'b0;
    end else if (ena) begin
      dp_q <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  assign dp = 1'b0;
`endif

  assign digit    = digit_q;
  assign segments = seg_q;
  assign tick     = tick_q;
  assign running  = running_q;

endmodule

// File: tb/tb_seg_display_sequencer.sv
// Self-checking bench for seg_display_sequencer with TICK_DIV = 4.
// Expected digits are queued as stimulus is applied and popped whenever the DUT ticks.
module tb_seg_display_sequencer;

  localparam int TD = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       stop;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic [6:0] segments;
  logic       tick;
  logic       running;
  logic       dp;

  int checks;
  int errors;
  logic [3:0] exp_q[$];

  seg_display_sequencer #(
    .TICK_DIV   (TD),
    .PRESCALE_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .digit    (digit),
    .segments (segments),
    .tick     (tick),
    .running  (running),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // One clock; any tick seen is scored against the head of the expectation queue.
  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick got digit=%0d seg=%h, required no tick", digit, segments);
      end else begin
        e = exp_q.pop_front();
        if (digit !== e || segments !== seg_ref(e)) begin
          errors++;
          $display("FAIL tick_digit got digit=%0d seg=%h, required digit=%0d seg=%h",
                   digit, segments, e, seg_ref(e));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
    dir = 1'b0; load = 1'b0; load_val = 4'd0;
    #23;
    checks++;
    if (digit !== 4'd0 || segments !== 7'h3F) begin
      errors++;
      $display("FAIL reset_digit got %0d/%h, required 0/3f", digit, segments);
    end
    checks++;
    if (tick !== 1'b0 || running !== 1'b0 || dp !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got tick=%b running=%b dp=%b, required 0 0 0", tick, running, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (running !== 1'b0 || tick !== 1'b0 || digit !== 4'd0) begin
        errors++;
        $display("FAIL idle_hold got running=%b tick=%b digit=%0d, required 0 0 0",
                 running, tick, digit);
      end
    end
  endtask

  task automatic test_count_up();
    logic exp_dp;
    dir = 1'b0;
    for (int d = 1; d <= 10; d++) exp_q.push_back(4'(d % 10));
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL start_running got %b, required 1", running);
    end
    for (int k = 1; k <= 10 * TD; k++) begin
      step();
      checks++;
      if (tick !== ((k % TD) == 0)) begin
        errors++;
        $display("FAIL up_tick_timing cycle %0d got tick=%b, required %b", k, tick, (k % TD) == 0);
      end
`ifdef SEG_DP_BLINK_EN
      exp_dp = (k % TD) < (TD / 2);
`else
      exp_dp = 1'b0;
`endif
      checks++;
      if (dp !== exp_dp) begin
        errors++;
        $display("FAIL dp_pattern cycle %0d got %b, required %b", k, dp, exp_dp);
      end
    end
  endtask

  task automatic test_count_down();
    dir = 1'b1;
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd8);
    for (int k = 1; k <= 2 * TD; k++) begin
      step();
      checks++;
      if (tick !== ((k % TD) == 0)) begin
        errors++;
        $display("FAIL down_tick_timing cycle %0d got tick=%b, required %b", k, tick, (k % TD) == 0);
      end
    end
    dir = 1'b0;
  endtask

  task automatic test_pause();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL pause_running got %b, required 0", running);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || digit !== 4'd8) begin
        errors++;
        $display("FAIL pause_hold got tick=%b digit=%0d, required 0 8", tick, digit);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL resume got running=%b tick=%b, required 1 0", running, tick);
    end
    exp_q.push_back(4'd9);
    step();
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL resume_early_tick got %b, required 0", tick);
    end
    step();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL resume_tick got %b, required 1", tick);
    end
  endtask

  task automatic test_load();
    step();
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    checks++;
    if (digit !== 4'd3 || segments !== 7'h4F || tick !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL load_3 got digit=%0d seg=%h tick=%b running=%b, required 3 4f 0 1",
               digit, segments, tick, running);
    end
    step(); step();
    load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    checks++;
    if (digit !== 4'd9 || segments !== 7'h6F || running !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp got digit=%0d seg=%h running=%b, required 9 6f 1",
               digit, segments, running);
    end
    exp_q.push_back(4'd0);
    for (int k = 1; k <= TD; k++) begin
      step();
      checks++;
      if (tick !== (k == TD)) begin
        errors++;
        $display("FAIL load_period cycle %0d got tick=%b, required %b", k, tick, k == TD);
      end
    end
    step(); step(); step();
    load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0;
    checks++;
    if (tick !== 1'b0 || digit !== 4'd5) begin
      errors++;
      $display("FAIL load_at_tc got tick=%b digit=%0d, required 0 5", tick, digit);
    end
    exp_q.push_back(4'd6);
    for (int k = 1; k <= TD; k++) begin
      step();
      checks++;
      if (tick !== (k == TD)) begin
        errors++;
        $display("FAIL load_tc_period cycle %0d got tick=%b, required %b", k, tick, k == TD);
      end
    end
  endtask

  task automatic test_ena();
    step();
    ena = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || digit !== 4'd6 || running !== 1'b1) begin
        errors++;
        $display("FAIL ena_freeze got tick=%b digit=%0d running=%b, required 0 6 1",
                 tick, digit, running);
      end
    end
    ena = 1'b1;
    exp_q.push_back(4'd7);
    for (int k = 1; k <= TD - 1; k++) begin
      step();
      checks++;
      if (tick !== (k == TD - 1)) begin
        errors++;
        $display("FAIL ena_resume cycle %0d got tick=%b, required %b", k, tick, k == TD - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (digit !== 4'd0 || segments !== 7'h3F || running !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got digit=%0d seg=%h running=%b tick=%b, required 0 3f 0 0",
               digit, segments, running, tick);
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * TD; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || running !== 1'b0 || digit !== 4'd0) begin
        errors++;
        $display("FAIL post_reset_idle got tick=%b running=%b digit=%0d, required 0 0 0",
                 tick, running, digit);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_load();
    test_ena();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ticks got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
